// File: rtl/clk_rst_ctrl.sv
// Clock-enable prescaler and reset sequencer: merges the external pin and the
// watchdog power-on/manual requests into stretched, prioritised system resets.
module clk_rst_ctrl #(
    parameter int HOLD_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        EXT_RES_N,
    input  logic        PRES,
    input  logic        MRES,
    output logic        CLK2_CE,
    output logic        CLK64_CE,
    output logic        CLK128_CE,
    output logic        CLK256_CE,
    output logic        CLK512_CE,
    output logic        CLK1024_CE,
    output logic        CLK4096_CE,
    output logic        CLK8192_CE,
    output logic        WDT_RES_N,
    output logic        SYS_PRES_N,
    output logic        SYS_MRES_N,
    output logic [1:0]  RST_SRC,
    output logic [1:0]  dbg_state,
    output logic [12:0] dbg_ps
);

    localparam logic [7:0] HOLD = 8'(HOLD_CYC);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_EXT   = 2'd1,
        ST_PHOLD = 2'd2,
        ST_MHOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hc_q, hc_d;
    logic [1:0]  src_q, src_d;
    logic [12:0] ps_q, ps_d;
    logic [7:0]  strb_q, strb_d;
    logic        wdt_q, wdt_d;
    logic        pres_n_q, pres_n_d;
    logic        mres_n_q, mres_n_d;
    logic        ext_s1_q, ext_s_q;
    logic        accept;

    // The pin is asynchronous, so it is resynchronised on every CLK edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ext_s1_q <= 1'b0;
            ext_s_q  <= 1'b0;
        end else begin
            ext_s1_q <= EXT_RES_N;
            ext_s_q  <= ext_s1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        src_d    = src_q;
        ps_d     = ps_q;
        strb_d   = strb_q;
        wdt_d    = wdt_q;
        pres_n_d = pres_n_q;
        mres_n_d = mres_n_q;
        accept   = 1'b0;
        if (CE_R) begin
            if (!ext_s_q) begin
                state_d = ST_EXT;
                hc_d    = HOLD;
                src_d   = 2'b01;
            end else begin
                case (state_q)
                    ST_RUN: accept = 1'b1;
                    ST_EXT: begin
                        if (hc_q == 8'd1) accept = 1'b1;
                        else              hc_d = hc_q - 8'd1;
                    end
                    ST_PHOLD: begin
                        if (PRES)               hc_d = HOLD;
                        else if (hc_q == 8'd1)  accept = 1'b1;
                        else                    hc_d = hc_q - 8'd1;
                    end
                    ST_MHOLD: begin
                        if (PRES) begin
                            state_d = ST_PHOLD;
                            hc_d    = HOLD;
                            src_d   = 2'b10;
                        end else if (MRES) begin
                            hc_d = HOLD;
                        end else if (hc_q == 8'd1) begin
                            accept = 1'b1;
                        end else begin
                            hc_d = hc_q - 8'd1;
                        end
                    end
                    default: accept = 1'b1;
                endcase
                // Leaving a hold evaluates requests exactly as RUN would, so no dead cycle.
                if (accept) begin
                    if (PRES) begin
                        state_d = ST_PHOLD;
                        hc_d    = HOLD;
                        src_d   = 2'b10;
                    end else if (MRES) begin
                        state_d = ST_MHOLD;
                        hc_d    = HOLD;
                        src_d   = 2'b11;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            if (state_d == ST_EXT) begin
                ps_d   = 13'd0;
                strb_d = 8'd0;
            end else begin
                ps_d      = ps_q + 13'd1;
                strb_d[0] = &ps_q[0:0];
                strb_d[1] = &ps_q[5:0];
                strb_d[2] = &ps_q[6:0];
                strb_d[3] = &ps_q[7:0];
                strb_d[4] = &ps_q[8:0];
                strb_d[5] = &ps_q[9:0];
                strb_d[6] = &ps_q[11:0];
                strb_d[7] = &ps_q[12:0];
            end

            wdt_d    = (state_d != ST_EXT);
            pres_n_d = !((state_d == ST_EXT) || (state_d == ST_PHOLD));
            mres_n_d = (state_d != ST_MHOLD);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_EXT;
            hc_q     <= HOLD;
            src_q    <= 2'b00;
            ps_q     <= 13'd0;
            strb_q   <= 8'd0;
            wdt_q    <= 1'b0;
            pres_n_q <= 1'b0;
            mres_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            src_q    <= src_d;
            ps_q     <= ps_d;
            strb_q   <= strb_d;
            wdt_q    <= wdt_d;
            pres_n_q <= pres_n_d;
            mres_n_q <= mres_n_d;
        end
    end

    assign CLK2_CE    = strb_q[0];
    assign CLK64_CE   = strb_q[1];
    assign CLK128_CE  = strb_q[2];
    assign CLK256_CE  = strb_q[3];
    assign CLK512_CE  = strb_q[4];
    assign CLK1024_CE = strb_q[5];
    assign CLK4096_CE = strb_q[6];
    assign CLK8192_CE = strb_q[7];
    assign WDT_RES_N  = wdt_q;
    assign SYS_PRES_N = pres_n_q;
    assign SYS_MRES_N = mres_n_q;
    assign RST_SRC    = src_q;
    assign dbg_state  = state_q;
    assign dbg_ps     = ps_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Bench for clk_rst_ctrl: randomized and directed stimulus against a
// behavioural model of the prescaler count and the reset-hold rules.
module tb_clk_rst_ctrl;
  localparam int HOLD = 16;
  localparam logic [25:0] RESET_VEC = {8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 13'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce_r = 1'b0;
  logic ext_res_n = 1'b1;
  logic pres = 1'b0;
  logic mres = 1'b0;
  logic clk2_ce, clk64_ce, clk128_ce, clk256_ce, clk512_ce, clk1024_ce, clk4096_ce, clk8192_ce;
  logic wdt_res_n, sys_pres_n, sys_mres_n;
  logic [1:0] rst_src, dbg_state;
  logic [12:0] dbg_ps;
  logic [25:0] dut_vec;

  int checks = 0;
  int errors = 0;

  clk_rst_ctrl #(.HOLD_CYC(HOLD)) dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .EXT_RES_N(ext_res_n),
    .PRES(pres), .MRES(mres),
    .CLK2_CE(clk2_ce), .CLK64_CE(clk64_ce), .CLK128_CE(clk128_ce), .CLK256_CE(clk256_ce),
    .CLK512_CE(clk512_ce), .CLK1024_CE(clk1024_ce), .CLK4096_CE(clk4096_ce),
    .CLK8192_CE(clk8192_ce), .WDT_RES_N(wdt_res_n), .SYS_PRES_N(sys_pres_n),
    .SYS_MRES_N(sys_mres_n), .RST_SRC(rst_src), .dbg_state(dbg_state), .dbg_ps(dbg_ps)
  );

  assign dut_vec = {clk8192_ce, clk4096_ce, clk1024_ce, clk512_ce, clk256_ce, clk128_ce,
                    clk64_ce, clk2_ce, wdt_res_n, sys_pres_n, sys_mres_n, rst_src, dbg_ps};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // m_mode: 0 running, 1 external reset, 2 power-on hold, 3 manual hold
  int m_mode, m_left, m_src, m_cnt;
  bit m_sync0, m_sync1;

  function automatic int div_of(int i);
    case (i)
      0: return 2;
      1: return 64;
      2: return 128;
      3: return 256;
      4: return 512;
      5: return 1024;
      6: return 4096;
      default: return 8192;
    endcase
  endfunction

  function automatic logic [25:0] exp_vec();
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = (m_cnt > 0) && (m_cnt % div_of(i) == 0);
    return {s, 1'(m_mode != 1), 1'(!(m_mode == 1 || m_mode == 2)), 1'(m_mode != 3),
            2'(m_src), 13'(m_cnt % 8192)};
  endfunction

  task automatic model_reset();
    m_mode = 1; m_left = HOLD; m_src = 0; m_cnt = 0; m_sync0 = 0; m_sync1 = 0;
  endtask

  task automatic model_accept();
    if (pres) begin m_mode = 2; m_left = HOLD; m_src = 2; end
    else if (mres) begin m_mode = 3; m_left = HOLD; m_src = 3; end
    else m_mode = 0;
  endtask

  task automatic model_release_or_count();
    if (m_left == 1) model_accept();
    else m_left--;
  endtask

  task automatic model_step();
    bit es;
    es = m_sync1;
    m_sync1 = m_sync0;
    m_sync0 = ext_res_n;
    if (ce_r) begin
      if (!es) begin
        m_mode = 1; m_left = HOLD; m_src = 1;
      end else if (m_mode == 0) begin
        model_accept();
      end else if (m_mode == 1) begin
        model_release_or_count();
      end else if (m_mode == 2) begin
        if (pres) m_left = HOLD;
        else model_release_or_count();
      end else begin
        if (pres) begin m_mode = 2; m_left = HOLD; m_src = 2; end
        else if (mres) m_left = HOLD;
        else model_release_or_count();
      end
      m_cnt = (m_mode == 1) ? 0 : m_cnt + 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit ce, input bit e, input bit p, input bit m);
    ce_r = ce; ext_res_n = e; pres = p; mres = m;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, RESET_VEC);
    end
    rst_n = 1'b1;
    model_reset();
    n = 0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      tick(1, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
      end
      if (wdt_res_n === 1'b1 && sys_pres_n === 1'b1) n = i;
    end
    checks++;
    if (n != HOLD + 2) begin
      errors++; $display("FAIL reset_to_run_cycles: got %0d expected %0d", n, HOLD + 2);
    end
    checks++;
    if (rst_src !== 2'b01) begin
      errors++; $display("FAIL reset_src: got %b expected 01", rst_src);
    end
  endtask

  task automatic test_prescaler();
    int c2, c8192;
    c2 = 0; c8192 = 0;
    for (int i = 0; i < 8192; i++) begin
      tick(1, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL prescaler_full_rate: got %h expected %h", dut_vec, exp_vec());
      end
      c2 += int'(clk2_ce);
      c8192 += int'(clk8192_ce);
    end
    checks++;
    if (c8192 != 1) begin
      errors++; $display("FAIL clk8192_count: got %0d expected 1", c8192);
    end
    checks++;
    if (c2 != 4096) begin
      errors++; $display("FAIL clk2_count: got %0d expected 4096", c2);
    end
  endtask

  task automatic test_ce_half();
    int hi64;
    hi64 = 0;
    for (int i = 0; i < 1280; i++) begin
      tick(bit'(i % 2), 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL prescaler_half_rate: got %h expected %h", dut_vec, exp_vec());
      end
      hi64 += int'(clk64_ce);
    end
    checks++;
    if (hi64 != 20) begin
      errors++; $display("FAIL clk64_half_rate_high_clks: got %0d expected 20", hi64);
    end
  endtask

  task automatic test_pres();
    int low_p, low_w;
    low_p = 0; low_w = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 1, (i == 0), 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL pres_pulse: got %h expected %h", dut_vec, exp_vec());
      end
      low_p += int'(!sys_pres_n);
      low_w += int'(!wdt_res_n);
      if (i == 0) begin
        checks++;
        if (rst_src !== 2'b10) begin
          errors++; $display("FAIL pres_src: got %b expected 10", rst_src);
        end
      end
    end
    checks++;
    if (low_p != HOLD) begin
      errors++; $display("FAIL pres_low_cycles: got %0d expected %0d", low_p, HOLD);
    end
    checks++;
    if (low_w != 0) begin
      errors++; $display("FAIL pres_wdt_low_cycles: got %0d expected 0", low_w);
    end
  endtask

  task automatic test_mres_preempt();
    int low_p;
    for (int i = 0; i < 11; i++) tick(1, 1, 0, (i < 5));
    checks++;
    if (rst_src !== 2'b11 || sys_mres_n !== 1'b0) begin
      errors++; $display("FAIL mres_hold: got src=%b mres_n=%b expected src=11 mres_n=0", rst_src, sys_mres_n);
    end
    tick(1, 1, 1, 0);
    checks++;
    if (sys_mres_n !== 1'b1 || sys_pres_n !== 1'b0 || rst_src !== 2'b10) begin
      errors++;
      $display("FAIL mres_preempt: got mres_n=%b pres_n=%b src=%b expected 1 0 10", sys_mres_n, sys_pres_n, rst_src);
    end
    low_p = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL preempt_hold: got %h expected %h", dut_vec, exp_vec());
      end
      low_p += int'(!sys_pres_n);
    end
    checks++;
    if (low_p != HOLD) begin
      errors++; $display("FAIL preempt_low_cycles: got %0d expected %0d", low_p, HOLD);
    end
  endtask

  task automatic test_ext_in_phold();
    int n;
    tick(1, 1, 1, 0);
    repeat (4) tick(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    checks++;
    if (wdt_res_n !== 1'b0 || dbg_ps !== 13'd0 || rst_src !== 2'b01) begin
      errors++;
      $display("FAIL ext_in_phold: got wdt=%b ps=%0d src=%b expected 0 0 01", wdt_res_n, dbg_ps, rst_src);
    end
    repeat (3) tick(1, 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      tick(1, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ext_release: got %h expected %h", dut_vec, exp_vec());
      end
      if (wdt_res_n === 1'b1) n = i;
    end
    checks++;
    if (n != HOLD + 2) begin
      errors++; $display("FAIL ext_release_cycles: got %0d expected %0d", n, HOLD + 2);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 1, 1, 0);
    for (int i = 0; i < 100 && !(m_mode == 2 && m_left == 1); i++) tick(1, 1, 0, 0);
    tick(1, 1, 0, 1);
    checks++;
    if (sys_mres_n !== 1'b0 || sys_pres_n !== 1'b1 || rst_src !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back: got mres_n=%b pres_n=%b src=%b expected 0 1 11", sys_mres_n, sys_pres_n, rst_src);
    end
    for (int i = 0; i < HOLD + 2; i++) begin
      tick(1, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL back_to_back_hold: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_rst_mid_phold();
    tick(1, 1, 1, 0);
    repeat (3) tick(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, RESET_VEC);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit e, p, m, ce;
    int ext_left;
    ext_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(0, 199) == 0) ext_left = $urandom_range(1, 8);
      e = (ext_left == 0);
      ce = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 49) == 0);
      m = ($urandom_range(0, 29) == 0);
      tick(ce, e, p, m);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_prescaler();
    test_ce_half();
    test_pres();
    test_mres_preempt();
    test_ext_in_phold();
    test_back_to_back();
    test_rst_mid_phold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
